iterative_alu: RTL and testbench



---
 rtl/iterative_alu.sv | 108 ++++++++++
 tb/tb_iterative_alu.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/iterative_alu.sv
// Execute-stage ALU with a 1-bit-per-cycle serial shifter and valid/ready handshakes.
// Non-shift ops finish in one cycle; shifts take one extra cycle per bit of shift amount.
module iterative_alu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      ALUControl,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALUResult,
    output logic            Zero,
    output logic            busy
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpAnd  = 4'd2;
    localparam logic [3:0] OpOr   = 4'd3;
    localparam logic [3:0] OpSlt  = 4'd4;
    localparam logic [3:0] OpSll  = 4'd5;
    localparam logic [3:0] OpSltu = 4'd6;
    localparam logic [3:0] OpXor  = 4'd7;
    localparam logic [3:0] OpSrl  = 4'd8;
    localparam logic [3:0] OpSra  = 4'd9;

    state_e            r_state;
    logic [3:0]        r_op;
    logic [4:0]        r_cnt;
    logic [XLEN-1:0]   r_result;

    logic [XLEN-1:0]   w_alu_result;
    logic              w_is_shift;
    logic              w_accept;

    assign w_is_shift = (ALUControl == OpSll) || (ALUControl == OpSrl) ||
                        (ALUControl == OpSra);
    assign w_accept   = in_valid && (r_state == StIdle);

    // Single-cycle datapath; undefined codes fall through to ADD like the decoder.
    always_comb begin
        w_alu_result = SrcA + SrcB;
        case (ALUControl)
            OpSub:   w_alu_result = SrcA - SrcB;
            OpAnd:   w_alu_result = SrcA & SrcB;
            OpOr:    w_alu_result = SrcA | SrcB;
            OpXor:   w_alu_result = SrcA ^ SrcB;
            OpSlt:   w_alu_result = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            OpSltu:  w_alu_result = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
            default: w_alu_result = SrcA + SrcB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= StIdle;
            r_op     <= OpAdd;
            r_cnt    <= 5'd0;
            r_result <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_op  <= ALUControl;
                        r_cnt <= SrcB[4:0];
                        if (w_is_shift) begin
                            r_result <= SrcA;
                            r_state  <= (SrcB[4:0] == 5'd0) ? StDone : StShift;
                        end else begin
                            r_result <= w_alu_result;
                            r_state  <= StDone;
                        end
                    end
                end
                StShift: begin
                    case (r_op)
                        OpSll:   r_result <= {r_result[XLEN-2:0], 1'b0};
                        OpSrl:   r_result <= {1'b0, r_result[XLEN-1:1]};
                        default: r_result <= {r_result[XLEN-1], r_result[XLEN-1:1]};
                    endcase
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1) begin
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign busy      = (r_state != StIdle);
    assign ALUResult = r_result;
    assign Zero      = (r_result == '0);

endmodule

// File: tb/tb_iterative_alu.sv
// Randomized self-checking bench for iterative_alu against a plain-arithmetic reference model.
module tb_iterative_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALUControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    iterative_alu #(.XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                                 input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd5:    return a << sh;
            4'd6:    return (a < b) ? 32'd1 : 32'd0;
            4'd7:    return a ^ b;
            4'd8:    return a >> sh;
            4'd9:    return $unsigned($signed(a) >>> sh);
            default: return a + b;
        endcase
    endfunction

    function automatic int model_latency(input logic [3:0] op, input logic [31:0] b);
        if ((op == 4'd5 || op == 4'd8 || op == 4'd9) && (b % 32) != 0) return 1 + int'(b % 32);
        return 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("idle_wait", {31'd0, in_ready}, 32'd1);
    endtask

    // Issue one op, track latency, apply back-pressure for `hold` cycles, then drain.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
        logic [31:0] exp;
        int          lat;
        exp = model_result(op, a, b);
        wait_idle();
        in_valid   = 1'b1;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        tick();
        lat        = 1;
        ALUControl = 4'($urandom);
        SrcA       = $urandom;
        SrcB       = $urandom;
        in_valid   = $urandom_range(0, 1) == 1;
        check("ready_low_after_accept", {31'd0, in_ready}, 32'd0);
        while (!out_valid && lat < 40) begin
            check("busy_while_working", {31'd0, busy}, 32'd1);
            tick();
            lat++;
        end
        check($sformatf("latency op%0d", op), lat, model_latency(op, b));
        check($sformatf("result op%0d", op), ALUResult, exp);
        check("zero", {31'd0, Zero}, {31'd0, exp == 32'd0});
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_result", ALUResult, exp);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("ready_after_handshake", {31'd0, in_ready}, 32'd1);
        check("valid_after_handshake", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        ALUControl = 4'd0;
        SrcA       = 32'd0;
        SrcB       = 32'd0;
        tick();
        tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", ALUResult, 32'd0);
        check("rst_zero", {31'd0, Zero}, 32'd1);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tick();

        do_op(4'd1, 32'd5, 32'd5, 0);
        do_op(4'd1, 32'd3, 32'd5, 0);
        do_op(4'd4, 32'hFFFF_FFFF, 32'd1, 0);
        do_op(4'd6, 32'hFFFF_FFFF, 32'd1, 0);
        do_op(4'd9, 32'h8000_0010, 32'h0000_0024, 3);
        do_op(4'd5, 32'h1234_5678, 32'd0, 0);
        do_op(4'd8, 32'h8000_0000, 32'd31, 1);
        do_op(4'd12, 32'd100, 32'd23, 0);

        // Abort a long shift with reset; it must never produce a result.
        wait_idle();
        in_valid   = 1'b1;
        ALUControl = 4'd5;
        SrcA       = 32'h0000_0001;
        SrcB       = 32'd20;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 30; i++) begin
            if (out_valid) check("abort_spurious_valid", {31'd0, out_valid}, 32'd0);
            tick();
        end
        check("abort_no_valid", {31'd0, out_valid}, 32'd0);
        do_op(4'd0, 32'd7, 32'd8, 0);

        for (int n = 0; n < 150; n++) begin
            logic [31:0] b;
            b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
            do_op(4'($urandom_range(0, 15)), $urandom, b, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
